// File: rtl/definesPkg.sv
// Shared AHB-Lite definitions for the word-addressed RAM slave.
// Bus widths, transfer encodings and error-response FSM states.
package definesPkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int HSIZE_WIDTH   = 3;
  localparam int BURST_SIZE    = 3;
  localparam int TRANSFER_TYPE = 2;

  typedef enum logic [TRANSFER_TYPE-1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    NON_SEQ = 2'b10,
    SEQ     = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY,
    ERR1,
    ERR2
  } resp_state_t;

  localparam logic [HSIZE_WIDTH-1:0] SZ_BYTE = 3'b000;
  localparam logic [HSIZE_WIDTH-1:0] SZ_HALF = 3'b001;
  localparam logic [HSIZE_WIDTH-1:0] SZ_WORD = 3'b010;

endpackage

// File: rtl/ahb_slave_mem.sv
// Word RAM: masked synchronous write, registered read.
// A read of the word being written returns the merged value.
module ahb_slave_mem #(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 256,
  parameter string INIT_FILE  = "",
  parameter int    AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] wmask,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] merged;

  assign merged = (mem[waddr] & ~wmask)
                | (wdata & wmask);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= merged;
    if (re) begin
      if (we && (waddr == raddr)) rdata <= merged;
      else rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/modport_slave.sv
// AHB-Lite RAM slave with a read-only window and two-cycle
// ERROR response; zero wait states on every legal transfer.
module modport_slave
  import definesPkg::*;
#(
  parameter int    ADDRESS_WIDTH = definesPkg::ADDRESS_WIDTH,
  parameter int    DATA_WIDTH    = definesPkg::DATA_WIDTH,
  parameter int    MEM_DEPTH     = 256,
  parameter int    RO_BASE       = 0,
  parameter int    RO_LIMIT      = 15,
  parameter string INIT_FILE     = ""
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [ADDRESS_WIDTH-1:0] HADDR,
  input  logic                     HWRITE,
  input  logic [HSIZE_WIDTH-1:0]   HSIZE,
  input  logic [BURST_SIZE-1:0]    HBURST,
  input  logic [TRANSFER_TYPE-1:0] HTRANS,
  input  logic [DATA_WIDTH-1:0]    HWDATA,
  output logic [DATA_WIDTH-1:0]    HRDATA,
  output logic                     HREADY,
  output logic                     HRESP
);

  localparam int IW = $clog2(MEM_DEPTH);

  resp_state_t state_q, state_d;

  logic                   accept;
  logic                   in_ro;
  logic                   oor;
  logic                   bad_size;
  logic                   err;
  logic                   rd_go;
  logic                   wr_q;
  logic                   rd_q;
  logic [IW-1:0]          waddr_q;
  logic [HSIZE_WIDTH-1:0] wsize_q;
  logic [DATA_WIDTH-1:0]  wmask;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic                   unused_burst;

  assign unused_burst = ^HBURST;

  assign HREADY = (state_q != ERR1);
  assign HRESP  = (state_q == ERR1)
               || (state_q == ERR2);

  assign accept = HREADY
               && ((htrans_t'(HTRANS) == NON_SEQ)
               ||  (htrans_t'(HTRANS) == SEQ));

  // Offset compare keeps the window test valid when RO_BASE is 0.
  assign in_ro = (HADDR - ADDRESS_WIDTH'(RO_BASE))
              <= ADDRESS_WIDTH'(RO_LIMIT - RO_BASE);
  assign oor = HADDR >= ADDRESS_WIDTH'(MEM_DEPTH);
  assign bad_size = HSIZE > SZ_WORD;
  assign err = (HWRITE && in_ro) || oor || bad_size;

  assign rd_go = accept && !err && !HWRITE;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state_q <= OKAY;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = OKAY;
    unique case (state_q)
      ERR1:    state_d = ERR2;
      default: state_d = (accept && err) ? ERR1 : OKAY;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      waddr_q <= '0;
      wsize_q <= SZ_BYTE;
    end else begin
      wr_q <= accept && !err && HWRITE;
      rd_q <= rd_go;
      if (accept) begin
        waddr_q <= HADDR[IW-1:0];
        wsize_q <= HSIZE;
      end
    end
  end

  always_comb begin
    wmask = '1;
    unique case (1'b1)
      wsize_q == SZ_BYTE:
        wmask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
      wsize_q == SZ_HALF:
        wmask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
      default:
        wmask = '1;
    endcase
  end

  // Reset on the committing edge drops the pending write.
  ahb_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .INIT_FILE  (INIT_FILE),
    .AW         (IW)
  ) u_mem (
    .clk   (HCLK),
    .we    (wr_q && HRESETn),
    .waddr (waddr_q),
    .wdata (HWDATA),
    .wmask (wmask),
    .re    (rd_go),
    .raddr (HADDR[IW-1:0]),
    .rdata (mem_rdata)
  );

  assign HRDATA = rd_q ? mem_rdata : '0;

endmodule

// File: tb/tb_modport_slave.sv
// Bench for modport_slave: directed AHB scenarios plus random
// bursts against a word-map model of the slave.
module tb_modport_slave;
  import definesPkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [2:0]  HBURST = 3'b000;
  logic [1:0]  HTRANS = 2'b00;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport_slave dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .HADDR  (HADDR),
    .HWRITE (HWRITE),
    .HSIZE  (HSIZE),
    .HBURST (HBURST),
    .HTRANS (HTRANS),
    .HWDATA (HWDATA),
    .HRDATA (HRDATA),
    .HREADY (HREADY),
    .HRESP  (HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] mdata  [int unsigned];
  logic [31:0] mknown [int unsigned];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic beat_t mk(input logic [1:0] t,
                               input logic w,
                               input logic [2:0] s,
                               input logic [31:0] a,
                               input logic [31:0] d);
    beat_t b;
    b.trans = t;
    b.write = w;
    b.size  = s;
    b.addr  = a;
    b.data  = d;
    return b;
  endfunction

  function automatic logic [31:0] size_mask(input logic [2:0] s);
    if (s == 3'd0) return 32'h0000_00FF;
    if (s == 3'd1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  // Illegal: write into words 0..15, beyond 256 words, or size > word.
  function automatic bit is_err(input beat_t b);
    return (b.write && b.addr <= 32'd15)
        || (b.addr >= 32'd256)
        || (b.size > 3'd2);
  endfunction

  task automatic model_write(input logic [31:0] a,
                             input logic [2:0] s,
                             input logic [31:0] d);
    logic [31:0] m, o, k;
    m = size_mask(s);
    o = mdata.exists(a) ? mdata[a] : 32'h0;
    k = mknown.exists(a) ? mknown[a] : 32'h0;
    mdata[a]  = (o & ~m) | (d & m);
    mknown[a] = k | m;
  endtask

  task automatic model_read(input string tag,
                            input logic [31:0] a,
                            input logic [31:0] got);
    logic [31:0] o, k;
    o = mdata.exists(a) ? mdata[a] : 32'h0;
    k = mknown.exists(a) ? mknown[a] : 32'h0;
    if (k != 32'h0) check({tag, "/hrdata"}, got & k, o & k);
    mdata[a]  = (o & k) | (got & ~k);
    mknown[a] = 32'hFFFF_FFFF;
  endtask

  // Pipelined master: address phase of beat i overlaps data phase of i-1.
  task automatic run(input string tag, input beat_t bq[$]);
    int i, cyc, limit;
    bit pend_w, in_err1, prev1, rdy, acc, e, has_rd;
    logic [31:0] pend_d, ra;
    beat_t b;
    i = 0; cyc = 0; limit = bq.size() * 3 + 10;
    pend_w = 0; in_err1 = 0; pend_d = '0; ra = '0;
    while ((i < bq.size() || pend_w || in_err1) && cyc < limit) begin
      b = (i < bq.size()) ? bq[i] : '0;
      HTRANS = b.trans;
      HADDR  = b.addr;
      HWRITE = b.write;
      HSIZE  = b.size;
      HBURST = 3'b011;
      HWDATA = pend_w ? pend_d : $urandom;
      rdy = !in_err1;
      acc = rdy && b.trans[1];
      e = acc && is_err(b);
      has_rd = 0;
      pend_w = 0;
      if (acc && !e) begin
        if (b.write) begin
          pend_w = 1;
          pend_d = b.data;
          model_write(b.addr, b.size, b.data);
        end else begin
          has_rd = 1;
          ra = b.addr;
        end
      end
      @(posedge HCLK); #1;
      cyc++;
      if (rdy && i < bq.size()) i++;
      prev1 = in_err1;
      in_err1 = e;
      check({tag, "/hready"}, {31'b0, HREADY}, {31'b0, !e});
      check({tag, "/hresp"}, {31'b0, HRESP}, {31'b0, e || prev1});
      if (has_rd) model_read(tag, ra, HRDATA);
      if (e) check({tag, "/err_hrdata"}, HRDATA, 32'h0);
    end
    check({tag, "/beats_done"}, i, bq.size());
    HTRANS = IDLE;
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  initial begin
    beat_t q[$];
    logic [31:0] a0;
    logic [2:0] sz;
    int blen, r;
    bit w;

    HRESETn = 1'b0;
    repeat (3) tick();
    check("reset/hready", {31'b0, HREADY}, 32'd1);
    check("reset/hresp", {31'b0, HRESP}, 32'd0);
    check("reset/hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    tick();

    q = '{mk(NON_SEQ, 1, 3'd2, 32'h40, 32'hDEADBEEF)};
    run("single_wr", q);
    q = '{mk(NON_SEQ, 0, 3'd2, 32'h40, 32'h0)};
    run("single_rd", q);

    q = '{mk(NON_SEQ, 1, 3'd2, 32'h20, 32'd1),
          mk(SEQ,     1, 3'd2, 32'h21, 32'd2),
          mk(SEQ,     1, 3'd2, 32'h22, 32'd3),
          mk(SEQ,     1, 3'd2, 32'h23, 32'd4)};
    run("incr4_wr", q);
    q = '{mk(NON_SEQ, 0, 3'd2, 32'h20, 32'd0),
          mk(SEQ,     0, 3'd2, 32'h21, 32'd0),
          mk(SEQ,     0, 3'd2, 32'h22, 32'd0),
          mk(SEQ,     0, 3'd2, 32'h23, 32'd0)};
    run("incr4_rd", q);

    q = '{mk(NON_SEQ, 0, 3'd2, 32'h20, 32'd0),
          mk(BUSY,    0, 3'd2, 32'h21, 32'd0),
          mk(SEQ,     0, 3'd2, 32'h21, 32'd0),
          mk(BUSY,    0, 3'd2, 32'h22, 32'd0),
          mk(BUSY,    0, 3'd2, 32'h22, 32'd0),
          mk(SEQ,     0, 3'd2, 32'h22, 32'd0),
          mk(SEQ,     0, 3'd2, 32'h23, 32'd0)};
    run("incr4_busy", q);

    q = '{mk(NON_SEQ, 1, 3'd2, 32'h30, 32'h12345678),
          mk(NON_SEQ, 0, 3'd2, 32'h30, 32'h0),
          mk(NON_SEQ, 1, 3'd0, 32'h30, 32'hFFFFFFAA),
          mk(NON_SEQ, 0, 3'd2, 32'h30, 32'h0),
          mk(NON_SEQ, 1, 3'd1, 32'h30, 32'hFFFFBEEF),
          mk(NON_SEQ, 0, 3'd2, 32'h30, 32'h0)};
    run("fwd_lanes", q);

    q = '{mk(NON_SEQ, 0, 3'd2, 32'h03, 32'h0),
          mk(NON_SEQ, 1, 3'd2, 32'h03, 32'h5),
          mk(NON_SEQ, 0, 3'd2, 32'h03, 32'h0)};
    run("ro_write", q);

    q = '{mk(NON_SEQ, 0, 3'd2, 32'h1000, 32'h0),
          mk(NON_SEQ, 1, 3'd3, 32'h40, 32'h12345678),
          mk(NON_SEQ, 0, 3'd2, 32'h40, 32'h0)};
    run("oor_size", q);

    HTRANS = NON_SEQ; HADDR = 32'h40; HWRITE = 0; HSIZE = 3'd2;
    tick();
    check("rst_rd/before", HRDATA, 32'hDEADBEEF);
    HTRANS = IDLE; HRESETn = 1'b0;
    tick();
    check("rst_rd/hrdata", HRDATA, 32'h0);
    check("rst_rd/hready", {31'b0, HREADY}, 32'd1);
    check("rst_rd/hresp", {31'b0, HRESP}, 32'd0);
    HRESETn = 1'b1;
    tick();

    q = '{mk(NON_SEQ, 1, 3'd2, 32'h50, 32'h11111111)};
    run("rst_wr_pre", q);
    HTRANS = NON_SEQ; HADDR = 32'h50; HWRITE = 1; HSIZE = 3'd2;
    tick();
    HTRANS = IDLE; HWDATA = 32'h22222222; HRESETn = 1'b0;
    tick();
    check("rst_wr/hready", {31'b0, HREADY}, 32'd1);
    check("rst_wr/hresp", {31'b0, HRESP}, 32'd0);
    check("rst_wr/hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    tick();
    q = '{mk(NON_SEQ, 0, 3'd2, 32'h50, 32'h0)};
    run("rst_wr_post", q);

    q = {};
    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r < 6) a0 = $urandom_range(0, 47);
      else if (r < 8) a0 = $urandom_range(240, 270);
      else a0 = $urandom_range(0, 15);
      r = $urandom_range(0, 3);
      blen = (r == 0) ? 1 : (r == 1) ? 4 : (r == 2) ? 8 : 16;
      w = $urandom_range(0, 1) == 1;
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      for (int k = 0; k < blen; k++) begin
        if (k > 0 && $urandom_range(0, 5) == 0)
          q.push_back(mk(BUSY, w, sz, a0 + k, 32'h0));
        q.push_back(mk(k == 0 ? NON_SEQ : SEQ, w, sz, a0 + k, $urandom));
      end
      if ($urandom_range(0, 3) == 0)
        q.push_back(mk(IDLE, 0, 3'd2, 32'h0, 32'h0));
    end
    run("random", q);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
